// File: rtl/pe_frame_loader.sv
// Frame loader for the averaging PE: buffers one frame of samples in a local RAM,
// hands the RAM port to the PE, runs it once, and returns sum/count on a result port.
module pe_frame_loader #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          i_s_valid,
  output logic          o_s_ready,
  input  logic [DW-1:0] i_s_data,
  input  logic          i_s_last,
  output logic          o_pe_req,
  output logic [31:0]   o_pe_dataNum,
  input  logic          i_pe_busy,
  input  logic [DW-1:0] i_pe_return,
  input  logic [31:0]   i_pe_addr,
  input  logic [DW-1:0] i_pe_datain,
  input  logic          i_pe_r_w,
  input  logic          i_pe_ce,
  output logic [DW-1:0] o_pe_dataout,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [DW-1:0] o_res_sum,
  output logic [AW:0]   o_res_count,
  output logic          o_res_trunc
);

  typedef enum logic [2:0] {LOAD, REQ, WAIT_HI, WAIT_LO, RESULT} state_t;

  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d, cnt_inc;
  logic          trunc_q, trunc_d;
  logic          rdy_q, rdy_d;
  logic [31:0]   dnum_q, dnum_d;
  logic [DW-1:0] sum_q, sum_d;
  logic [AW:0]   rcnt_q, rcnt_d;
  logic          rtrunc_q, rtrunc_d;
  logic          accept;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we, ram_re;
  logic [DW-1:0] mem_q [0:2**AW-1];
  logic [DW-1:0] rdata_q;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^i_pe_addr[31:AW];

  // ready is registered so it only rises on the first enabled edge out of reset
  assign o_s_ready    = rdy_q & ce;
  assign accept       = i_s_valid & o_s_ready;
  assign cnt_inc      = cnt_q + 1'b1;
  assign o_pe_req     = (state_q == REQ);
  assign o_res_valid  = (state_q == RESULT);
  assign o_pe_dataNum = dnum_q;
  assign o_res_sum    = sum_q;
  assign o_res_count  = rcnt_q;
  assign o_res_trunc  = rtrunc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trunc_d  = trunc_q;
    dnum_d   = dnum_q;
    sum_d    = sum_q;
    rcnt_d   = rcnt_q;
    rtrunc_d = rtrunc_q;
    case (state_q)
      LOAD: if (accept) begin
        cnt_d = cnt_inc;
        if (i_s_last || cnt_q == LAST_IDX) begin
          trunc_d = ~i_s_last;
          dnum_d  = 32'(cnt_inc);
          state_d = REQ;
        end
      end
      REQ:     state_d = WAIT_HI;
      WAIT_HI: if (i_pe_busy) state_d = WAIT_LO;
      WAIT_LO: if (!i_pe_busy) begin
        sum_d    = i_pe_return;
        rcnt_d   = cnt_q;
        rtrunc_d = trunc_q;
        state_d  = RESULT;
      end
      RESULT: if (i_res_ready) begin
        cnt_d   = '0;
        trunc_d = 1'b0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    rdy_d = (state_d == LOAD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
      rdy_q    <= 1'b0;
      dnum_q   <= '0;
      sum_q    <= '0;
      rcnt_q   <= '0;
      rtrunc_q <= 1'b0;
    end else if (ce) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
      rdy_q    <= rdy_d;
      dnum_q   <= dnum_d;
      sum_q    <= sum_d;
      rcnt_q   <= rcnt_d;
      rtrunc_q <= rtrunc_d;
    end
  end

  // RAM port belongs to the loader only while filling; the PE owns it otherwise
  always_comb begin
    if (state_q == LOAD) begin
      ram_addr  = cnt_q[AW-1:0];
      ram_wdata = i_s_data;
      ram_we    = accept;
      ram_re    = 1'b0;
    end else begin
      ram_addr  = i_pe_addr[AW-1:0];
      ram_wdata = i_pe_datain;
      ram_we    = i_pe_ce & i_pe_r_w;
      ram_re    = i_pe_ce & ~i_pe_r_w;
    end
  end

  always_ff @(posedge clock) begin
    if (ce) begin
      if (ram_we) mem_q[ram_addr] <= ram_wdata;
      if (ram_re) rdata_q <= mem_q[ram_addr];
    end
  end

  assign o_pe_dataout = rdata_q;

endmodule
